// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding, opcode
// constants, destination and source-select codes, decoded control bundle.
package program_sequencer_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned IR_W     = 8;
    localparam int unsigned SRC_W    = 4;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned REG_EN_W = 9;
    localparam int unsigned DST_W    = 3;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_TARGET = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Control-flow opcodes
    localparam logic [IR_W-1:0] OP_JMP  = 8'hE0;
    localparam logic [IR_W-1:0] OP_JZ   = 8'hE1;
    localparam logic [IR_W-1:0] OP_JNZ  = 8'hE2;
    localparam logic [IR_W-1:0] OP_HALT = 8'hFF;

    // Destination codes carried in the instruction
    localparam logic [DST_W-1:0] DST_X0 = 3'd0;
    localparam logic [DST_W-1:0] DST_X1 = 3'd1;
    localparam logic [DST_W-1:0] DST_Y0 = 3'd2;
    localparam logic [DST_W-1:0] DST_Y1 = 3'd3;
    localparam logic [DST_W-1:0] DST_O  = 3'd4;
    localparam logic [DST_W-1:0] DST_M  = 3'd5;
    localparam logic [DST_W-1:0] DST_I  = 3'd6;
    localparam logic [DST_W-1:0] DST_DM = 3'd7;

    // Source-select codes driven to the computational unit
    localparam logic [SRC_W-1:0] SRC_X0   = 4'd0;
    localparam logic [SRC_W-1:0] SRC_X1   = 4'd1;
    localparam logic [SRC_W-1:0] SRC_Y0   = 4'd2;
    localparam logic [SRC_W-1:0] SRC_Y1   = 4'd3;
    localparam logic [SRC_W-1:0] SRC_R    = 4'd4;
    localparam logic [SRC_W-1:0] SRC_M    = 4'd5;
    localparam logic [SRC_W-1:0] SRC_I    = 4'd6;
    localparam logic [SRC_W-1:0] SRC_DM   = 4'd7;
    localparam logic [SRC_W-1:0] SRC_IMM  = 4'd8;
    localparam logic [SRC_W-1:0] SRC_RSV9 = 4'd9;

    // reg_en bit positions that are not equal to the destination code
    localparam int unsigned REN_R = 4;
    localparam int unsigned REN_O = 8;

    // INIT pulses the r enable so the unit clears r and sets r_eq_0
    localparam logic [REG_EN_W-1:0] REG_EN_INIT = 9'h010;

    typedef struct packed {
        logic [REG_EN_W-1:0] reg_en;
        logic [SRC_W-1:0]    source_sel;
        logic [NIB_W-1:0]    ir_nibble;
        logic                i_sel;
        logic                x_sel;
        logic                y_sel;
        logic                is_jmp;
        logic                is_jz;
        logic                is_jnz;
        logic                is_halt;
    } ctrl_t;

    // One-hot register enable for a destination code (o_reg lives at bit 8)
    function automatic logic [REG_EN_W-1:0] dst_reg_en(input logic [DST_W-1:0] dst);
        logic [REG_EN_W-1:0] en;
        en = '0;
        if (dst == DST_O) begin
            en[REN_O] = 1'b1;
        end else begin
            en[dst] = 1'b1;
        end
        return en;
    endfunction

endpackage

// File: rtl/program_sequencer_instr_decoder.sv
// Instruction decoder: turns the instruction register into computational-unit
// control fields and control-flow flags. Purely combinational.
// Ports: ir (instruction register) in, ctrl (decoded control bundle) out.
module instr_decoder
    import program_sequencer_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output ctrl_t           ctrl
);

    logic [DST_W-1:0] mv_dst;
    logic [SRC_W-1:0] mv_src;

    assign mv_dst = ir[5:3];
    assign mv_src = {1'b0, ir[2:0]};

    always_comb begin
        ctrl = '0;
        casez (ir)
            8'b0???????: begin
                // load immediate
                ctrl.reg_en     = dst_reg_en(ir[6:4]);
                ctrl.source_sel = SRC_IMM;
                ctrl.ir_nibble  = ir[3:0];
            end
            8'b10??????: begin
                // register move; i <= i + m when moving i onto itself
                ctrl.reg_en     = dst_reg_en(mv_dst);
                ctrl.source_sel = mv_src;
                ctrl.i_sel      = (mv_dst == DST_I) && (mv_src == SRC_I);
            end
            8'b110?????: begin
                // ALU operation, result into r
                ctrl.reg_en[REN_R] = 1'b1;
                ctrl.x_sel         = ir[4];
                ctrl.y_sel         = ir[3];
                ctrl.ir_nibble     = {1'b0, ir[2:0]};
                ctrl.source_sel    = SRC_X0;
            end
            default: begin
                // 111x: control flow, everything unlisted is a NOP
                ctrl.is_jmp  = (ir == OP_JMP);
                ctrl.is_jz   = (ir == OP_JZ);
                ctrl.is_jnz  = (ir == OP_JNZ);
                ctrl.is_halt = (ir == OP_HALT);
            end
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions from program memory, holds pc/ir,
// sequences INIT/FETCH/EXEC/TARGET/HALT and drives the computational-unit
// controls during EXEC.
// Ports: clk, reset_n (async active-low), hold (FETCH stall), pm_data (program
// memory read data), r_eq_0 (ALU zero flag) in; pm_addr, sync_reset, i_sel,
// x_sel, y_sel, source_sel, reg_en, ir_nibble, halted out.
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hold,
    input  logic [IR_W-1:0]     pm_data,
    input  logic                r_eq_0,
    output logic [PC_W-1:0]     pm_addr,
    output logic                sync_reset,
    output logic                i_sel,
    output logic                x_sel,
    output logic                y_sel,
    output logic [SRC_W-1:0]    source_sel,
    output logic [REG_EN_W-1:0] reg_en,
    output logic [NIB_W-1:0]    ir_nibble,
    output logic                halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            taken_q, taken_d;
    ctrl_t           dec;

    instr_decoder u_decoder (
        .ir   (ir_q),
        .ctrl (dec)
    );

    // State, pc, ir and jump-taken registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        taken_d = taken_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!hold) begin
                    ir_d    = pm_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_jmp || dec.is_jz || dec.is_jnz) begin
                    // r_eq_0 reflects the last completed ALU instruction here
                    taken_d = dec.is_jmp || (dec.is_jz && r_eq_0) || (dec.is_jnz && !r_eq_0);
                    state_d = ST_TARGET;
                end else if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_TARGET: begin
                // pc points at the target byte; skip it when not taken
                pc_d    = taken_q ? pm_data : pc_q + PC_W'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Outputs are decoded from state and ir only; reset_n forces the reset values
    always_comb begin
        pm_addr    = pc_q;
        sync_reset = 1'b0;
        reg_en     = '0;
        source_sel = '0;
        ir_nibble  = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        halted     = 1'b0;
        if (!reset_n) begin
            sync_reset = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sync_reset = 1'b1;
                    reg_en     = REG_EN_INIT;
                end
                ST_EXEC: begin
                    reg_en     = dec.reg_en;
                    source_sel = dec.source_sel;
                    ir_nibble  = dec.ir_nibble;
                    i_sel      = dec.i_sel;
                    x_sel      = dec.x_sel;
                    y_sel      = dec.y_sel;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: random programs executed by an
// instruction-level reference model; per-cycle expectations queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hold;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] pm_addr;
    logic       sync_reset;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic [3:0] ir_nibble;
    logic       halted;

    always #5 clk = ~clk;

    logic [7:0] pm [256];
    assign pm_data = pm[pm_addr];

    program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hold       (hold),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_addr    (pm_addr),
        .sync_reset (sync_reset),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .ir_nibble  (ir_nibble),
        .halted     (halted)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic       addr_chk;
        logic [8:0] reg_en;
        logic [3:0] src;
        logic [3:0] nib;
        logic       i_sel;
        logic       x_sel;
        logic       y_sel;
        logic       sync;
        logic       halted;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] m_pc;

    function automatic logic [23:0] ctrl_bits(input exp_t e);
        return {e.reg_en, e.src, e.nib, e.i_sel, e.x_sel, e.y_sel, e.sync, e.halted};
    endfunction

    // Architectural register number -> enable bit (o_reg sits at bit 8)
    function automatic int dst_bit(input int d);
        return (d == 4) ? 8 : d;
    endfunction

    function automatic exp_t plain_rec(input logic [7:0] addr, input logic chk);
        exp_t e;
        e = '0;
        e.addr     = addr;
        e.addr_chk = chk;
        return e;
    endfunction

    function automatic exp_t reset_rec();
        exp_t e;
        e = plain_rec(8'h00, 1'b1);
        e.sync = 1'b1;
        return e;
    endfunction

    function automatic exp_t init_rec();
        exp_t e;
        e = reset_rec();
        e.reg_en = 9'h010;
        return e;
    endfunction

    function automatic exp_t halt_rec();
        exp_t e;
        e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    // Expected EXEC controls, from the instruction-set rules by value ranges
    function automatic exp_t exec_rec(input logic [7:0] ir);
        exp_t e;
        int   v, dst, src;
        e = '0;
        v = int'(ir);
        if (v < 128) begin
            dst      = v / 16;
            e.reg_en = 9'(1 << dst_bit(dst));
            e.src    = 4'd8;
            e.nib    = 4'(v % 16);
        end else if (v < 192) begin
            dst      = (v / 8) % 8;
            src      = v % 8;
            e.reg_en = 9'(1 << dst_bit(dst));
            e.src    = 4'(src);
            e.i_sel  = (dst == 6) && (src == 6);
        end else if (v < 224) begin
            e.reg_en = 9'h010;
            e.x_sel  = 1'((v / 16) % 2);
            e.y_sel  = 1'((v / 8) % 2);
            e.nib    = 4'(v % 8);
        end
        return e;
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0:       return 8'hE0;
            1:       return 8'hE1;
            2:       return 8'hE2;
            3:       return 8'hB6;
            4:       return 8'hB1;
            5:       return 8'h35;
            default: return 8'($urandom_range(0, 254));
        endcase
    endfunction

    // One clock cycle of stimulus plus its expected observation
    task automatic cycle(input logic rst, input logic h, input exp_t e, output logic rq);
        @(posedge clk);
        #1;
        reset_n = rst;
        hold    = h;
        r_eq_0  = 1'($urandom_range(0, 1));
        rq      = r_eq_0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        logic rq;
        cycle(1'b0, 1'b0, reset_rec(), rq);
        cycle(1'b0, 1'($urandom_range(0, 1)), reset_rec(), rq);
        cycle(1'b1, 1'($urandom_range(0, 1)), init_rec(), rq);
        m_pc = 8'h00;
    endtask

    // Execute one instruction of the reference model, cycle by cycle
    task automatic step_instr(input logic [8:0] force_op, input bit stop_early,
                              output bit hit_halt);
        int         nh;
        logic       rq;
        logic [7:0] ir;
        bit         is_j, tk;
        hit_halt = 1'b0;
        nh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int k = 0; k <= nh; k++) begin
            cycle(1'b1, 1'(k < nh), plain_rec(m_pc, 1'b1), rq);
            if (k == 0 && force_op[8]) pm[m_pc] = force_op[7:0];
        end
        ir   = pm[m_pc];
        m_pc = m_pc + 8'd1;
        cycle(1'b1, 1'($urandom_range(0, 1)), exec_rec(ir), rq);
        is_j = (ir == 8'hE0) || (ir == 8'hE1) || (ir == 8'hE2);
        tk   = (ir == 8'hE0) || (ir == 8'hE1 && rq) || (ir == 8'hE2 && !rq);
        if (is_j && !stop_early) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), plain_rec(m_pc, 1'b1), rq);
            m_pc = tk ? pm[m_pc] : m_pc + 8'd1;
        end
        hit_halt = (ir == 8'hFF);
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge
    initial begin
        exp_t        e;
        logic [23:0] a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {reg_en, source_sel, ir_nibble, i_sel, x_sel, y_sel, sync_reset, halted};
                checks++;
                if (a !== ctrl_bits(e)) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d: got reg_en/src/nib/i/x/y/sync/halt=%h expected %h",
                             cyc, a, ctrl_bits(e));
                end
                if (e.addr_chk) begin
                    checks++;
                    if (pm_addr !== e.addr) begin
                        errors++;
                        $display("FAIL pm_addr cycle %0d: got %h expected %h", cyc, pm_addr, e.addr);
                    end
                end
            end
        end
    end

    initial begin
        bit   hh, stop;
        int   nsteps;
        logic rq;
        logic [8:0] fop;
        reset_n = 1'b0;
        hold    = 1'b0;
        r_eq_0  = 1'b0;
        for (int a = 0; a < 256; a++) pm[a] = 8'h00;
        for (int run = 0; run < 24; run++) begin
            do_reset();
            for (int a = 0; a < 256; a++) pm[a] = rand_byte();
            case (run)
                0: begin pm[0] = 8'h35; pm[1] = 8'hE1; pm[2] = 8'h40; end
                1: begin pm[0] = 8'hE0; pm[1] = 8'hFE; pm[8'hFE] = 8'hE2; end
                2: begin pm[0] = 8'hB6; pm[1] = 8'hB1; end
                default: begin end
            endcase
            nsteps = int'($urandom_range(15, 60));
            for (int s = 0; s < nsteps; s++) begin
                fop  = 9'h000;
                stop = 1'b0;
                if (s == nsteps - 1 && run % 3 == 0) fop = 9'h1FF;
                if (s == nsteps - 1 && run % 3 == 1) begin
                    fop  = 9'h1E1;
                    stop = 1'b1;
                end
                step_instr(fop, stop, hh);
                if (hh) begin
                    for (int k = 0; k < 8; k++)
                        cycle(1'b1, 1'($urandom_range(0, 1)), halt_rec(), rq);
                    break;
                end
            end
        end
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: hold  in  1  stall request, honoured only in FETCH.
REQ-004 SHALL have port: pm_data  in  8  program-memory read data, combinational from pm_addr.
REQ-005 SHALL have port: r_eq_0  in  1  registered ALU-result-zero flag from computational unit.
REQ-006 SHALL have port: pm_addr  out  8  program-memory address.
REQ-007 SHALL have ports: sync_reset  out  1; i_sel, x_sel, y_sel  out  1 each; source_sel  out  4; reg_en  out  9; ir_nibble  out  4 (computational-unit controls).
REQ-008 SHALL have port: halted  out  1  high while in HALT.

Function
REQ-009 SHALL implement states INIT, FETCH, EXEC, TARGET, HALT; one instruction takes 2 cycles (FETCH, EXEC), jumps 3 (plus TARGET).
REQ-010 INIT SHALL last exactly one cycle after reset release: sync_reset=1, reg_en=9'h010 (clears r, sets r_eq_0), -> FETCH.
REQ-011 FETCH: pm_addr=pc; if hold=1 stay, no register changes; else ir<=pm_data, pc<=pc+1, -> EXEC.
REQ-012 EXEC SHALL decode ir and drive controls for exactly that cycle; in all other states reg_en=0 (except INIT), sync_reset=0.
REQ-013 Load immediate, ir[7]=0: dst=ir[6:4], source_sel=8, ir_nibble=ir[3:0].
REQ-014 Move, ir[7:6]=10: dst=ir[5:3], source_sel={1'b0,ir[2:0]} (0 x0..7 dm); ir_nibble=0.
REQ-015 dst decode: 0..3 reg_en bit 0..3; 4 bit 8 (o_reg); 5 bit 5 (m); 6 bit 6 (i); 7 bit 7 (dm write strobe).
REQ-016 Move with dst=6 and src=6 SHALL set i_sel=1 (i<=i+m); otherwise i_sel=0.
REQ-017 ALU, ir[7:5]=110: reg_en bit 4 only, x_sel=ir[4], y_sel=ir[3], ir_nibble={1'b0,ir[2:0]}, source_sel=0.
REQ-018 ir[7:0]=8'hE0 JMP, 8'hE1 JZ (taken if r_eq_0=1), 8'hE2 JNZ (taken if r_eq_0=0): reg_en=0; taken flag registered in EXEC; -> TARGET.
REQ-019 TARGET: pm_addr=pc; taken -> pc<=pm_data; not taken -> pc<=pc+1 (skip target byte); -> FETCH; hold ignored.
REQ-020 ir=8'hFF SHALL -> HALT; HALT holds all state, reg_en=0, halted=1, until reset_n asserted.
REQ-021 All other ir[7:4]=111x encodings SHALL be NOPs (reg_en=0) -> FETCH.
REQ-022 pc SHALL be 8 bits, wrapping 8'hFF -> 8'h00 without flag; target byte fetched at 8'hFF reads address 8'hFF then pc wraps.
REQ-023 r_eq_0 SHALL be sampled in EXEC of the jump, i.e. reflecting the last completed ALU instruction.
REQ-024 Outputs SHALL be decoded combinationally from state and ir only (no pm_data paths to controls).

Reset
REQ-025 reset_n=0 SHALL immediately force state=INIT, pc=0, ir=0, taken=0, at any point including mid-jump or HALT.
REQ-026 During reset: pm_addr=0, reg_en=0, sync_reset=1, select outputs 0, halted=0.

Structure
REQ-027 Shared package SHALL hold state encoding, opcode constants (E0/E1/E2/FF), dst codes and source_sel codes 0..9.
REQ-028 Instruction decode SHALL be one sub-module instr_decoder (ir in, control fields out); FSM and pc stay in top.

Verification
REQ-029 Release reset -> 1 cycle sync_reset=1, reg_en=9'h010, then FETCH with pm_addr=0.
REQ-030 pm[0]=8'h35 -> EXEC: source_sel=8, ir_nibble=5, reg_en=9'h008; pm_addr=1 next FETCH.
REQ-031 pm[0]=8'hE1, pm[1]=8'h40, r_eq_0=1 -> pc=8'h40 after TARGET; same with r_eq_0=0 -> pc=2.
REQ-032 pm=8'hB6 (move i<=i) -> EXEC i_sel=1, reg_en=9'h040; 8'hB1 -> i_sel=0, source_sel=1.
REQ-033 hold=1 for 3 cycles in FETCH -> pc, ir constant, reg_en=0; resumes on hold=0.
REQ-034 pm=8'hFF -> halted=1, reg_en=0 indefinitely; reset_n low mid-HALT -> INIT, pc=0.
